// File: rtl/rx_frame_buffer_pkg.sv
// Shared types and helpers for the receive frame buffer.
// Read op-size encoding, byte-count helper and per-slot metadata.
package rx_frame_buffer_pkg;

  localparam int unsigned OP_SIZE_W = 3;
  localparam int unsigned SIZE_W    = 16;

  localparam logic [OP_SIZE_W-1:0] OP_1B  = 3'd0;
  localparam logic [OP_SIZE_W-1:0] OP_2B  = 3'd1;
  localparam logic [OP_SIZE_W-1:0] OP_4B  = 3'd2;
  localparam logic [OP_SIZE_W-1:0] OP_8B  = 3'd3;
  localparam logic [OP_SIZE_W-1:0] OP_16B = 3'd4;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic              err;
  } slot_meta_t;

  function automatic int unsigned op_bytes(input logic [OP_SIZE_W-1:0] op);
    return 32'(1) << op;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or write per cycle, registered read data.
module bsg_mem_1rw_sync #(
  parameter  int unsigned width_p       = 64,
  parameter  int unsigned els_p         = 256,
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic                     v_i,
  input  logic                     w_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) r_mem[addr_i] <= data_i;
  end

  // Read register holds its value between reads; cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)           r_data <= '0;
    else if (v_i & ~w_i)   r_data <= r_mem[addr_i];
  end

  assign data_o = r_data;

endmodule

// File: rtl/rx_read_align.sv
// Captures read op size/offset and right-justifies the selected bytes
// of the RAM word that arrives one cycle later, zero-extended.
module rx_read_align
  import rx_frame_buffer_pkg::*;
#(
  parameter  int unsigned data_width_p = 64,
  localparam int unsigned bytes_lp     = data_width_p / 8,
  localparam int unsigned lg_bytes_lp  = $clog2(bytes_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [lg_bytes_lp-1:0]  addr_i,
  input  logic [OP_SIZE_W-1:0]    op_size_i,
  input  logic [data_width_p-1:0] word_i,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o
);

  logic [OP_SIZE_W-1:0]    r_op;
  logic [lg_bytes_lp-1:0]  r_off;
  logic                    r_v;
  logic [data_width_p-1:0] w_shifted;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op  <= '0;
      r_off <= '0;
      r_v   <= 1'b0;
    end else begin
      r_v <= v_i;
      if (v_i) begin
        r_op  <= op_size_i;
        r_off <= addr_i & ~lg_bytes_lp'(op_bytes(op_size_i) - 1);
      end
    end
  end

  always_comb begin
    w_shifted = word_i >> {r_off, 3'b000};
    data_o    = '0;
    for (int b = 0; b < int'(bytes_lp); b++) begin
      if (32'(b) < op_bytes(r_op)) data_o[8*b +: 8] = w_shifted[8*b +: 8];
    end
  end

  assign v_o = r_v;

endmodule

// File: rtl/rx_frame_buffer.sv
// Multi-slot MAC receive frame buffer: fill/commit/abort on the write side,
// FIFO-ordered sized byte reads and release on the read side.
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter  int unsigned slot_p        = 2,
  parameter  int unsigned data_width_p  = 64,
  parameter  int unsigned els_p         = 2048,
  parameter  int unsigned size_width_p  = SIZE_W,
  parameter  int unsigned drop_width_p  = 16,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     write_slot_avail_o,
  input  logic                     write_v_i,
  input  logic [addr_width_lp-1:0] write_addr_i,
  input  logic [data_width_p-1:0]  write_data_i,
  input  logic                     write_commit_v_i,
  input  logic [size_width_p-1:0]  write_commit_size_i,
  input  logic                     write_commit_err_i,
  input  logic                     write_abort_i,
  output logic                     read_slot_v_o,
  output logic [size_width_p-1:0]  read_size_o,
  output logic                     read_err_o,
  input  logic                     read_release_i,
  input  logic                     read_v_i,
  input  logic [addr_width_lp-1:0] read_addr_i,
  input  logic [OP_SIZE_W-1:0]     read_op_size_i,
  output logic [data_width_p-1:0]  read_data_o,
  output logic                     read_data_v_o,
  output logic [drop_width_p-1:0]  drop_count_o
);

  localparam int unsigned bytes_lp    = data_width_p / 8;
  localparam int unsigned lg_bytes_lp = $clog2(bytes_lp);
  localparam int unsigned words_lp    = els_p / bytes_lp;
  localparam int unsigned waddr_w_lp  = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int unsigned ptr_w_lp    = (slot_p > 1) ? $clog2(slot_p) : 1;
  localparam int unsigned cnt_w_lp    = $clog2(slot_p + 1);

  logic [ptr_w_lp-1:0]     r_wptr, r_rptr, r_rd_slot;
  logic [cnt_w_lp-1:0]     r_count;
  logic [drop_width_p-1:0] r_drop;
  slot_meta_t              r_meta [slot_p];

  logic                    w_full, w_commit, w_commit_ok, w_drop, w_release, w_wr, w_rd;
  logic [waddr_w_lp-1:0]   w_wr_word, w_rd_word;
  logic [data_width_p-1:0] w_mem_data [slot_p];

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(slot_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Abort overrides commit; availability is judged on the registered count only.
  always_comb begin
    w_full      = (r_count == cnt_w_lp'(slot_p));
    w_commit    = write_commit_v_i & ~write_abort_i;
    w_commit_ok = w_commit & ~w_full;
    w_drop      = w_commit & w_full;
    w_release   = read_release_i & (r_count != '0);
    w_wr        = write_v_i & ~w_full;
    w_rd        = read_v_i & (r_count != '0);
    w_wr_word   = waddr_w_lp'(write_addr_i >> lg_bytes_lp);
    w_rd_word   = waddr_w_lp'(read_addr_i >> lg_bytes_lp);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rd_slot <= '0;
      r_count   <= '0;
      r_drop    <= '0;
      for (int s = 0; s < int'(slot_p); s++) r_meta[s] <= '0;
    end else begin
      if (w_commit_ok) begin
        r_meta[r_wptr] <= '{size: SIZE_W'(write_commit_size_i), err: write_commit_err_i};
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_release)                 r_rptr    <= ptr_inc(r_rptr);
      if (w_rd)                      r_rd_slot <= r_rptr;
      if (w_drop && (r_drop != '1))  r_drop    <= r_drop + 1'b1;
      r_count <= r_count + cnt_w_lp'(w_commit_ok) - cnt_w_lp'(w_release);
    end
  end

  // Write and read never target the same slot: reads need a committed head,
  // writes need a free fill slot, and the two coincide only when empty or full.
  for (genvar s = 0; s < slot_p; s++) begin : g_slot
    logic w_we, w_re;
    assign w_we = w_wr & (r_wptr == ptr_w_lp'(s));
    assign w_re = w_rd & (r_rptr == ptr_w_lp'(s));
    bsg_mem_1rw_sync #(.width_p(data_width_p), .els_p(words_lp)) u_mem (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (write_data_i),
      .addr_i  (w_we ? w_wr_word : w_rd_word),
      .v_i     (w_we | w_re),
      .w_i     (w_we),
      .data_o  (w_mem_data[s])
    );
  end

  rx_read_align #(.data_width_p(data_width_p)) u_align (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (w_rd),
    .addr_i    (read_addr_i[lg_bytes_lp-1:0]),
    .op_size_i (read_op_size_i),
    .word_i    (w_mem_data[r_rd_slot]),
    .data_o    (read_data_o),
    .v_o       (read_data_v_o)
  );

  assign write_slot_avail_o = ~w_full;
  assign read_slot_v_o      = (r_count != '0);
  assign read_size_o        = size_width_p'(r_meta[r_rptr].size);
  assign read_err_o         = r_meta[r_rptr].err;
  assign drop_count_o       = r_drop;

  // Alignment/size misuse checks for simulation.
  always @(posedge clk_i) begin
    if (!reset_i && write_v_i)
      assert ((write_addr_i & addr_width_lp'(bytes_lp - 1)) == '0)
        else $error("rx_frame_buffer: misaligned write addr %h", write_addr_i);
    if (!reset_i && read_v_i) begin
      assert (read_op_size_i <= OP_SIZE_W'(lg_bytes_lp))
        else $error("rx_frame_buffer: oversize read op %0d", read_op_size_i);
      assert ((read_addr_i & addr_width_lp'(op_bytes(read_op_size_i) - 1)) == '0)
        else $error("rx_frame_buffer: misaligned read addr %h", read_addr_i);
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: directed literal checks plus randomized traffic
// compared each cycle against a queue-based frame model.
module tb_rx_frame_buffer;

  localparam int unsigned SLOTS = 2;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 11;
  localparam int unsigned BDW   = 128;
  localparam int unsigned BAW   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          avail, wv, cv, cerr, abort, slot_v, rerr, rel, rv, rdv;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;
  logic [15:0]   csize, rsize, drop;
  logic [2:0]    rop;

  logic           b_avail, b_wv, b_cv, b_cerr, b_abort, b_slot_v, b_rerr, b_rel, b_rv, b_rdv;
  logic [BAW-1:0] b_waddr, b_raddr;
  logic [BDW-1:0] b_wdata, b_rdata;
  logic [15:0]    b_csize, b_rsize, b_drop;
  logic [2:0]     b_rop;

  rx_frame_buffer #(.slot_p(SLOTS), .data_width_p(DW), .els_p(2048)) dut (
    .clk_i(clk), .reset_i(reset), .write_slot_avail_o(avail), .write_v_i(wv),
    .write_addr_i(waddr), .write_data_i(wdata), .write_commit_v_i(cv),
    .write_commit_size_i(csize), .write_commit_err_i(cerr), .write_abort_i(abort),
    .read_slot_v_o(slot_v), .read_size_o(rsize), .read_err_o(rerr),
    .read_release_i(rel), .read_v_i(rv), .read_addr_i(raddr), .read_op_size_i(rop),
    .read_data_o(rdata), .read_data_v_o(rdv), .drop_count_o(drop));

  rx_frame_buffer #(.slot_p(1), .data_width_p(BDW), .els_p(64)) dut_b (
    .clk_i(clk), .reset_i(reset), .write_slot_avail_o(b_avail), .write_v_i(b_wv),
    .write_addr_i(b_waddr), .write_data_i(b_wdata), .write_commit_v_i(b_cv),
    .write_commit_size_i(b_csize), .write_commit_err_i(b_cerr), .write_abort_i(b_abort),
    .read_slot_v_o(b_slot_v), .read_size_o(b_rsize), .read_err_o(b_rerr),
    .read_release_i(b_rel), .read_v_i(b_rv), .read_addr_i(b_raddr), .read_op_size_i(b_rop),
    .read_data_o(b_rdata), .read_data_v_o(b_rdv), .drop_count_o(b_drop));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: physical slot contents plus a FIFO of committed frames.
  typedef struct { int slot; int size; bit err; } frame_t;
  logic [63:0] m_mem [SLOTS][256];
  frame_t      m_q[$];
  int          m_head = 0;
  int unsigned m_drop = 0;
  logic [63:0] m_data = '0;
  bit          m_dv = 0;
  bit          chk_en = 0;

  function automatic void model_step();
    int cnt, fill, nb;
    bit full;
    logic [63:0] word;
    if (reset) begin
      m_q.delete(); m_head = 0; m_drop = 0; m_data = '0; m_dv = 0;
      return;
    end
    cnt  = m_q.size();
    full = (cnt == SLOTS);
    fill = (m_head + cnt) % SLOTS;
    m_dv = rv && (cnt != 0);
    if (m_dv) begin
      word   = m_mem[m_q[0].slot][int'(raddr) / 8];
      nb     = 1 << rop;
      m_data = word >> (8 * (int'(raddr) % 8));
      if (nb < 8) m_data = m_data & ((64'd1 << (8 * nb)) - 64'd1);
    end
    if (wv && !full) m_mem[fill][int'(waddr) / 8] = wdata;
    if (cv && !abort) begin
      if (!full) m_q.push_back('{fill, int'(csize), cerr});
      else if (m_drop != 32'hffff) m_drop++;
    end
    if (rel && cnt != 0) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % SLOTS;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("avail", avail, m_q.size() != SLOTS);
      chk("slot_v", slot_v, m_q.size() != 0);
      chk("drop", drop, 16'(m_drop));
      chk("rdata_v", rdv, m_dv);
      chk("rdata", rdata, m_data);
      if (m_q.size() != 0) begin
        chk("size", rsize, 16'(m_q[0].size));
        chk("err", rerr, m_q[0].err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    wv = 0; waddr = '0; wdata = '0; cv = 0; csize = '0; cerr = 0; abort = 0;
    rel = 0; rv = 0; raddr = '0; rop = '0;
    b_wv = 0; b_waddr = '0; b_wdata = '0; b_cv = 0; b_csize = '0; b_cerr = 0; b_abort = 0;
    b_rel = 0; b_rv = 0; b_raddr = '0; b_rop = '0;
  endtask

  task automatic write_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      wv = 1; waddr = AW'(i * 8);
      wdata = (base == 8'h10 && i == 2) ? 64'h0807060504030201 : {8{8'(base + 8'(i))}};
      tick();
    end
    wv = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_avail"}, avail, 1'b1);
    chk({tag, "_slot_v"}, slot_v, 1'b0);
    chk({tag, "_size"}, rsize, 16'd0);
    chk({tag, "_err"}, rerr, 1'b0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_rdv"}, rdv, 1'b0);
    chk({tag, "_drop"}, drop, 16'd0);
  endtask

  initial begin
    idle();
    reset = 1; tick(); tick();
    reset = 0;
    check_reset_vals("rst");
    chk("b_rst_avail", b_avail, 1'b1);
    chk("b_rst_rdata", b_rdata, 128'd0);
    chk_en = 1;

    // Fill slot 0, commit, then sized reads.
    write_frame(8'h10);
    cv = 1; csize = 16'd60; cerr = 0; tick(); cv = 0;
    chk("t1_slot_v", slot_v, 1'b1);
    chk("t1_size", rsize, 16'd60);
    chk("t1_model_size", m_q[0].size, 60);
    rv = 1; rop = 3'd3; raddr = AW'(8); tick();
    chk("t1_rdv", rdv, 1'b1);
    chk("t1_rdata", rdata, 64'h1111111111111111);
    rop = 3'd0; raddr = AW'('h13); tick();
    chk("t2_byte", rdata, 64'h04);
    rop = 3'd1; raddr = AW'('h12); tick();
    chk("t2_half", rdata, 64'h0403);
    rop = 3'd2; raddr = AW'('h14); tick();
    chk("t2_word", rdata, 64'h08070605);
    chk("t2_model", m_data, 64'h08070605);
    rv = 0; tick();
    chk("t2_hold_v", rdv, 1'b0);
    chk("t2_hold", rdata, 64'h08070605);

    // Second frame fills the buffer; third commit drops.
    write_frame(8'hb0);
    cv = 1; csize = 16'd100; cerr = 1; tick();
    chk("t3_full", avail, 1'b0);
    wv = 1; waddr = '0; wdata = 64'hdeadbeefdeadbeef; csize = 16'd7; tick(); wv = 0;
    chk("t3_drop", drop, 16'd1);
    chk("t3_avail", avail, 1'b0);

    // Full: commit + release + read in one cycle.
    csize = 16'd9; rel = 1; rv = 1; rop = 3'd3; raddr = '0; tick();
    cv = 0; rel = 0; rv = 0;
    chk("t5_drop", drop, 16'd2);
    chk("t5_size", rsize, 16'd100);
    chk("t5_err", rerr, 1'b1);
    chk("t5_rdata", rdata, 64'h1010101010101010);
    chk("t5_avail", avail, 1'b1);

    // Drain, read while empty, abort, then replacement frame.
    rel = 1; tick(); rel = 0;
    chk("t4_empty", slot_v, 1'b0);
    rv = 1; tick(); rv = 0;
    chk("t4_rd_empty", rdv, 1'b0);
    write_frame(8'haa);
    abort = 1; tick();
    cv = 1; csize = 16'd5; tick(); cv = 0; abort = 0;
    chk("t4_abort_slot_v", slot_v, 1'b0);
    chk("t4_abort_drop", drop, 16'd2);
    write_frame(8'h5a);
    cv = 1; csize = 16'd64; cerr = 0; tick(); cv = 0;
    rv = 1; rop = 3'd3; raddr = AW'(8); tick(); rv = 0;
    chk("t4_new_data", rdata, 64'h5b5b5b5b5b5b5b5b);
    chk("t4_size", rsize, 16'd64);
    chk("t4_drop", drop, 16'd2);

    // Reset in the middle of a frame.
    rel = 1; tick(); rel = 0;
    wv = 1; waddr = '0; wdata = 64'h1; tick();
    wv = 0; cv = 1; csize = 16'd32; tick(); cv = 0;
    wv = 1; waddr = AW'(8); wdata = 64'h2; reset = 1; tick();
    reset = 0; wv = 0;
    check_reset_vals("mid");

    // 128-bit, single-slot instance.
    b_wv = 1; b_waddr = '0; b_wdata = 128'h0f0e0d0c0b0a09080706050403020100; tick();
    b_wv = 0; b_cv = 1; b_csize = 16'd16; tick(); b_cv = 0;
    chk("b_slot_v", b_slot_v, 1'b1);
    chk("b_full", b_avail, 1'b0);
    chk("b_size", b_rsize, 16'd16);
    b_rv = 1; b_rop = 3'd4; b_raddr = '0; tick();
    chk("b_full_word", b_rdata, 128'h0f0e0d0c0b0a09080706050403020100);
    b_rop = 3'd2; b_raddr = BAW'(8); tick();
    chk("b_word", b_rdata, 128'h0b0a0908);
    b_rop = 3'd0; b_raddr = BAW'(15); tick(); b_rv = 0;
    chk("b_byte", b_rdata, 128'h0f);
    b_rel = 1; tick(); b_rel = 0;
    chk("b_released", b_slot_v, 1'b0);
    chk("b_avail", b_avail, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int wd;
      reset = ($urandom_range(0, 499) == 0);
      wv    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, 7) * 8);
      wdata = {$urandom, $urandom};
      cv    = ($urandom_range(0, 9) == 0);
      csize = 16'($urandom_range(1, 1518));
      cerr  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 19) == 0);
      rel   = ($urandom_range(0, 7) == 0);
      rv    = 1'($urandom_range(0, 1));
      rop   = 3'($urandom_range(0, 3));
      wd    = int'($urandom_range(0, 7));
      raddr = AW'(wd * 8 + (int'($urandom_range(0, 7)) & ~((1 << rop) - 1)));
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Multi-slot receive frame buffer between the 1G MAC receive path and the PL/host read port. It generalises the fixed-width slot buffer in four ways: configurable slot depth, data width of 32, 64 or 128 bits, per-frame commit/abort, and an error flag per frame. The MAC writes into the current fill slot and then either commits the frame (size + error flag) or aborts it. Committed frames are presented in FIFO order to the reader, which performs sized, aligned byte-addressed reads and then releases the slot.

## Interface
- slot_p, 2: number of frame slots, ≥1, power of two.
- data_width_p, 64: memory word width; 32, 64 or 128.
- els_p, 2048: bytes per slot, power of two, ≥ data_width_p/8.
- size_width_p, 16: frame size field width.
- drop_width_p, 16: drop counter width.
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- write_slot_avail_o  out  1  a free fill slot exists.
- write_v_i  in  1  word write strobe.
- write_addr_i  in  clog2(els_p)  byte address, aligned to data_width_p/8.
- write_data_i  in  data_width_p  write word.
- write_commit_v_i  in  1  frame end; enqueue the fill slot.
- write_commit_size_i  in  size_width_p  frame length in bytes.
- write_commit_err_i  in  1  frame had FCS/PHY error.
- write_abort_i  in  1  discard the current fill.
- read_slot_v_o  out  1  a committed frame is at the head.
- read_size_o  out  size_width_p  head frame size.
- read_err_o  out  1  head frame error flag.
- read_release_i  in  1  dequeue the head slot.
- read_v_i  in  1  read request to the head slot.
- read_addr_i  in  clog2(els_p)  byte address.
- read_op_size_i  in  3  log2 of bytes: 0=1B … 4=16B; must not exceed log2(data_width_p/8).
- read_data_o  out  data_width_p  zero-extended, right-justified read data.
- read_data_v_o  out  1  read_data_o valid.
- drop_count_o  out  drop_width_p  saturating count of dropped frames.

## Operation
- Slot tracking: write pointer, read pointer and occupancy counter (0..slot_p). Full when count==slot_p; write_slot_avail_o = ~full; read_slot_v_o = count≠0.
- Writes: accepted only while write_slot_avail_o; the word is stored at write_addr_i>>log2(bytes) in slot wptr. Writes while full are ignored.
- Commit: if avail, latch size and err into the wptr slot registers, advance wptr, count+1. If not avail, drop_count_o+1, saturating at all-ones.
- Abort: no pointer change; the next frame overwrites the slot. Commit and abort in the same cycle: abort wins, no drop count.
- Release: when read_slot_v_o, advance rptr, count−1. Release while empty is ignored.
- Commit and release in the same cycle: both take effect. avail uses registered count, so commit while full with a simultaneous release still drops.
- Reads: when read_v_i & read_slot_v_o, slot rptr is read. read_data_o = (word >> 8·(addr mod bytes) aligned to op size) masked to 2^op_size bytes. read_v_i while empty: no memory access, read_data_v_o stays 0.
- Read together with release: the read is served from the releasing slot (slot select is registered).
- Misaligned write/read or an oversize op: simulation-only $error; behaviour is undefined.

## Timing
- Reset values: write_slot_avail_o=1, read_slot_v_o=0, read_size_o=0, read_err_o=0, read_data_o=0, read_data_v_o=0, drop_count_o=0; pointers and count are 0.
- Read latency: 1 cycle. read_data_v_o pulses the cycle after an accepted read_v_i; read_data_o holds its last value otherwise.
- Commit is visible at read_slot_v_o/read_size_o the next cycle.
- Release is visible at the next-head size/err the next cycle.
- Reset mid-frame discards all slots and clears the drop counter.

## Structure
- Package rx_frame_buffer_pkg: read op-size encoding constants, byte-count function, and a slot meta struct {size, err}.
- One per-slot bsg_mem_1rw_sync instance, generated per slot.
- Sub-module rx_read_align: registered op size and address, producing aligned zero-extended data.

## Test plan
- slot_p=2, data_width_p=64: write 8 words, commit size=60 err=0 → next cycle read_slot_v_o=1, read_size_o=60; 8-byte read at addr 8 returns word 1 one cycle later.
- Byte read at addr 0x13 of word 0x0807060504030201 at address 0x10 → read_data_o=0x04; 2-byte read at 0x12 → 0x0403.
- Commit three frames with slot_p=2 and no release → third drops, drop_count_o=1, write_slot_avail_o=0.
- Write frame, abort, write new frame, commit size=64 → reader sees only the new data, drop_count_o=0.
- Full buffer, commit and release in the same cycle → drop_count_o+1; head advances; read issued with release returns old-slot data.
- data_width_p=128, 16-byte read → full word; reset asserted mid-frame → all outputs at reset values next cycle.
